// File: rtl/cle283_seq_if.sv
// Signal bundle between the CLE283 sequencer and its surroundings: the
// diagnostic/boot controller (start/key/busy/done/err/result), the backplane
// arbiter (bus_req/bus_gnt) and the CLE283 strobe bus (ba*, sser_n, br_w, sdrd).
interface cle283_seq_if #(
  parameter int NBITS = 16
);
  // Controller side
  logic             start;
  logic [15:0]      key;
  logic             busy;
  logic             done;
  logic             err;
  logic [NBITS-1:0] result;

  // Arbiter side
  logic             bus_req;
  logic             bus_gnt;

  // Backplane strobe bus
  logic             ba13;
  logic             ba12;
  logic [3:0]       ba_lo;
  logic             sser_n;
  logic             br_w;
  logic             sdrd;

  // Environment view: controller, arbiter and CLE283 drive the inputs.
  modport master (
    output start, key, bus_gnt, sdrd,
    input  busy, done, err, result, bus_req, ba13, ba12, ba_lo, sser_n, br_w
  );

  // Sequencer view.
  modport slave (
    input  start, key, bus_gnt, sdrd,
    output busy, done, err, result, bus_req, ba13, ba12, ba_lo, sser_n, br_w
  );
endinterface

// File: rtl/cle283_seq.sv
// CLE283 serial-ID bus-cycle sequencer.
// On an accepted start it requests the backplane bus, issues four key strobes
// (key[15:12] first) to step the CLE283 ID state machine, then NBITS read
// strobes whose SDRD samples are shifted MSB-first into result. Losing the
// grant anywhere between the first grant and release aborts the run: the bus
// is dropped at once and done is pulsed with err set.
// Every bus output is registered; the next values are computed from the
// next-state so that an output always agrees with the state it belongs to.

// Strobe-bus hygiene properties, kept apart from the datapath.
module cle283_seq_chk (
  input logic       clk,
  input logic       rst,
  input logic       sser_n,
  input logic       ba13,
  input logic       ba12,
  input logic [3:0] ba_lo,
  input logic       br_w
);
  a_strobe_width: assert property (@(posedge clk) disable iff (rst)
    !sser_n |=> sser_n);
  a_strobe_window: assert property (@(posedge clk) disable iff (rst)
    !sser_n |-> (!ba13 && ba12));
  a_strobe_setup: assert property (@(posedge clk) disable iff (rst)
    !sser_n |-> $stable(ba_lo));
  a_read_only: assert property (@(posedge clk) disable iff (rst)
    br_w);
endmodule

module cle283_seq #(
  parameter int         NBITS    = 16,
  parameter logic [3:0] READ_NIB = 4'h0,
  parameter int         GAP      = 1
) (
  input logic         clk,
  input logic         rst,
  cle283_seq_if.slave bus
);

  // The strobe counter serves both the key phase (4) and the read phase
  // (NBITS); it is sized for the longer of the two and never wraps.
  localparam int MAX_STROBES = (NBITS > 4) ? NBITS : 4;
  localparam int CNT_W       = $clog2(MAX_STROBES);

  localparam logic [CNT_W-1:0] KEY_LAST  = CNT_W'(3);
  localparam logic [CNT_W-1:0] READ_LAST = CNT_W'(NBITS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [3:0]       GAP_LAST  = 4'(GAP - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_REQ   = 3'd1;
  localparam logic [2:0] ST_KEY   = 3'd2;
  localparam logic [2:0] ST_READ  = 3'd3;
  localparam logic [2:0] ST_REL   = 3'd4;
  localparam logic [2:0] ST_ABORT = 3'd5;

  // Append one sampled SDRD bit at the LSB; written without a part-select so
  // that NBITS=1 stays legal.
  function automatic logic [NBITS-1:0] shift_in(input logic [NBITS-1:0] word,
                                                input logic             bit_in);
    shift_in = (word << 1) | NBITS'(bit_in);
  endfunction

  // State and sequencing registers
  logic [2:0]       state_r,      state_s;
  logic [3:0]       gap_cnt_r,    gap_cnt_s;
  logic [CNT_W-1:0] strobe_cnt_r, strobe_cnt_s;
  logic             strobing_r,   strobing_s;   // 1 = strobe cycle, 0 = gap
  logic [15:0]      key_r,        key_s;        // next key nibble at [15:12]
  logic [NBITS-1:0] shift_r,      shift_s;

  // Registered outputs
  logic             busy_r,    busy_s;
  logic             done_r,    done_s;
  logic             err_r,     err_s;
  logic [NBITS-1:0] result_r,  result_s;
  logic             bus_req_r, bus_req_s;
  logic [3:0]       ba_lo_r,   ba_lo_s;
  logic             sser_n_r,  sser_n_s;
  logic             ba13_r,    ba13_s;
  logic             ba12_r,    ba12_s;
  logic             br_w_r;

  // Next-state and next-output computation for the whole sequencer.
  always_comb begin
    state_s      = state_r;
    gap_cnt_s    = gap_cnt_r;
    strobe_cnt_s = strobe_cnt_r;
    strobing_s   = strobing_r;
    key_s        = key_r;
    shift_s      = shift_r;
    busy_s       = busy_r;
    done_s       = 1'b0;
    err_s        = err_r;
    result_s     = result_r;
    bus_req_s    = bus_req_r;
    ba_lo_s      = ba_lo_r;

    case (state_r)
      ST_IDLE: begin
        strobing_s = 1'b0;
        ba_lo_s    = 4'h0;
        if (bus.start) begin
          state_s   = ST_REQ;
          key_s     = bus.key;
          shift_s   = '0;
          busy_s    = 1'b1;
          bus_req_s = 1'b1;
          err_s     = 1'b0;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_REQ: begin
        // No timeout: the arbiter is trusted to grant eventually.
        if (bus.bus_gnt) begin
          state_s      = ST_KEY;
          strobing_s   = 1'b0;
          gap_cnt_s    = 4'd0;
          strobe_cnt_s = '0;
          ba_lo_s      = key_r[15:12];
        end else begin
          state_s = ST_REQ;
        end
      end

      ST_KEY, ST_READ: begin
        if (!bus.bus_gnt) begin
          // Grant lost: release immediately; a strobe in flight is not sampled.
          state_s    = ST_ABORT;
          bus_req_s  = 1'b0;
          strobing_s = 1'b0;
          ba_lo_s    = 4'h0;
        end else if (!strobing_r) begin
          // Gap cycle: ba_lo already holds the upcoming nibble.
          if (gap_cnt_r == GAP_LAST) begin
            strobing_s = 1'b1;
            gap_cnt_s  = 4'd0;
          end else begin
            gap_cnt_s = gap_cnt_r + 4'd1;
          end
        end else begin
          // Strobe cycle ends at this edge.
          strobing_s = 1'b0;
          if (state_r == ST_KEY) begin
            key_s = {key_r[11:0], 4'h0};
            if (strobe_cnt_r == KEY_LAST) begin
              state_s      = ST_READ;
              strobe_cnt_s = '0;
              ba_lo_s      = READ_NIB;
            end else begin
              strobe_cnt_s = strobe_cnt_r + CNT_ONE;
              ba_lo_s      = key_r[11:8];
            end
          end else begin
            shift_s = shift_in(shift_r, bus.sdrd);
            if (strobe_cnt_r == READ_LAST) begin
              state_s      = ST_REL;
              strobe_cnt_s = '0;
              ba_lo_s      = 4'h0;
            end else begin
              strobe_cnt_s = strobe_cnt_r + CNT_ONE;
            end
          end
        end
      end

      ST_REL: begin
        state_s    = ST_IDLE;
        strobing_s = 1'b0;
        ba_lo_s    = 4'h0;
        bus_req_s  = 1'b0;
        busy_s     = 1'b0;
        done_s     = 1'b1;
        err_s      = 1'b0;
        result_s   = shift_r;
      end

      ST_ABORT: begin
        state_s    = ST_IDLE;
        strobing_s = 1'b0;
        ba_lo_s    = 4'h0;
        bus_req_s  = 1'b0;
        busy_s     = 1'b0;
        done_s     = 1'b1;
        err_s      = 1'b1;
      end

      default: begin
        // Unreachable encodings fall back to a released, idle bus.
        state_s      = ST_IDLE;
        strobing_s   = 1'b0;
        gap_cnt_s    = 4'd0;
        strobe_cnt_s = '0;
        ba_lo_s      = 4'h0;
        bus_req_s    = 1'b0;
        busy_s       = 1'b0;
      end
    endcase

    // The window select and strobe follow the strobe phase directly.
    sser_n_s = ~strobing_s;
    ba13_s   = ~strobing_s;
    ba12_s   = strobing_s;
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      gap_cnt_r    <= 4'd0;
      strobe_cnt_r <= '0;
      strobing_r   <= 1'b0;
      key_r        <= 16'h0000;
      shift_r      <= '0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      err_r        <= 1'b0;
      result_r     <= '0;
      bus_req_r    <= 1'b0;
      ba_lo_r      <= 4'h0;
      sser_n_r     <= 1'b1;
      ba13_r       <= 1'b1;
      ba12_r       <= 1'b0;
      br_w_r       <= 1'b1;
    end else begin
      state_r      <= state_s;
      gap_cnt_r    <= gap_cnt_s;
      strobe_cnt_r <= strobe_cnt_s;
      strobing_r   <= strobing_s;
      key_r        <= key_s;
      shift_r      <= shift_s;
      busy_r       <= busy_s;
      done_r       <= done_s;
      err_r        <= err_s;
      result_r     <= result_s;
      bus_req_r    <= bus_req_s;
      ba_lo_r      <= ba_lo_s;
      sser_n_r     <= sser_n_s;
      ba13_r       <= ba13_s;
      ba12_r       <= ba12_s;
      br_w_r       <= 1'b1;
    end
  end

  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.err     = err_r;
  assign bus.result  = result_r;
  assign bus.bus_req = bus_req_r;
  assign bus.ba13    = ba13_r;
  assign bus.ba12    = ba12_r;
  assign bus.ba_lo   = ba_lo_r;
  assign bus.sser_n  = sser_n_r;
  assign bus.br_w    = br_w_r;

  cle283_seq_chk u_chk (
    .clk    (clk),
    .rst    (rst),
    .sser_n (sser_n_r),
    .ba13   (ba13_r),
    .ba12   (ba12_r),
    .ba_lo  (ba_lo_r),
    .br_w   (br_w_r)
  );

endmodule

// File: tb/tb_cle283_seq.sv
// Bench for cle283_seq: a table of whole-run vectors (key, SDRD pattern,
// grant behaviour and the expected result/err/run length), a CLE283/arbiter
// responder that replays SDRD on read strobes, a scoreboard of expected done
// events, per-strobe timing and hygiene checks, and a reset-mid-key sequence.
module tb_cle283_seq;
  localparam int         NBITS    = 16;
  localparam int         GAP      = 1;
  localparam logic [3:0] READ_NIB = 4'h0;
  localparam int         PERIOD   = GAP + 1;

  logic clk;
  logic rst;
  int   cyc;
  int   n_cmp;
  int   n_bad;

  cle283_seq_if #(.NBITS(NBITS)) sio ();

  cle283_seq #(.NBITS(NBITS), .READ_NIB(READ_NIB), .GAP(GAP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sio)
  );

  typedef struct {
    logic [15:0] key;
    logic [15:0] data;        // SDRD pattern, MSB replayed first
    int          gnt_delay;   // cycles from bus_req to grant (0 = already high)
    int          drop_read;   // read strobe index where grant drops, -1 none
    int          extra_start; // cycle offset of a stray start, -1 none
    logic [15:0] exp_result;
    logic        exp_err;
    int          exp_len;     // cycles from start to done
  } vec_t;

  typedef struct {
    logic [15:0] result;
    logic        err;
    int          done_cyc;
  } exp_t;

  vec_t vecs[6];
  exp_t sb_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  task automatic check_idle_bus(input string tag);
    check({tag, "_sser_n"}, 32'(sio.sser_n), 32'd1);
    check({tag, "_ba13"},   32'(sio.ba13),   32'd1);
    check({tag, "_ba12"},   32'(sio.ba12),   32'd0);
    check({tag, "_ba_lo"},  32'(sio.ba_lo),  32'd0);
    check({tag, "_br_w"},   32'(sio.br_w),   32'd1);
  endtask

  function automatic logic [3:0] nib(input logic [15:0] k, input int i);
    nib = k[15 - 4*i -: 4];
  endfunction

  // One complete run from an idle DUT; called at a falling edge.
  task automatic run_vec(input vec_t v);
    int         t0;
    int         rel;
    int         k;
    int         drop_rel;
    bit         finished;
    logic       prev_sser_n;
    logic [3:0] prev_ba_lo;
    logic [3:0] exp_nib;
    exp_t       e;
    k        = 0;
    finished = 1'b0;
    drop_rel = (v.drop_read >= 0) ? (3 + v.gnt_delay + PERIOD * (4 + v.drop_read)) : -10;
    t0 = cyc;
    sio.start   = 1'b1;
    sio.key     = v.key;
    sio.bus_gnt = (v.gnt_delay == 0);
    e.result   = v.exp_result;
    e.err      = v.exp_err;
    e.done_cyc = t0 + v.exp_len;
    sb_q.push_back(e);
    prev_sser_n = sio.sser_n;
    prev_ba_lo  = sio.ba_lo;
    while (!finished) begin
      @(negedge clk);
      rel = cyc - t0;
      sio.start = (rel == v.extra_start);
      if (sio.start) sio.key = 16'hFFFF;
      check("br_w", 32'(sio.br_w), 32'd1);
      if (rel == 1) begin
        check("busy_rise", 32'(sio.busy),    32'd1);
        check("req_rise",  32'(sio.bus_req), 32'd1);
        check("err_clear", 32'(sio.err),     32'd0);
      end
      if (v.gnt_delay > 0 && rel == 1 + v.gnt_delay) sio.bus_gnt = 1'b1;
      if (rel == drop_rel + 1) begin
        check_idle_bus("abort");
        check("abort_req", 32'(sio.bus_req), 32'd0);
      end
      if (!sio.sser_n) begin
        exp_nib = (k < 4) ? nib(v.key, k) : READ_NIB;
        check("strobe_cyc",   rel, 3 + v.gnt_delay + PERIOD * k);
        check("strobe_nib",   32'(sio.ba_lo), 32'(exp_nib));
        check("strobe_win",   32'({sio.ba13, sio.ba12}), 32'd1);
        check("strobe_width", 32'(prev_sser_n), 32'd1);
        check("ba_lo_setup",  32'(sio.ba_lo), 32'(prev_ba_lo));
        sio.sdrd = (k >= 4) ? v.data[NBITS - 1 - (k - 4)] : 1'b0;
        if (v.drop_read >= 0 && k == 4 + v.drop_read) sio.bus_gnt = 1'b0;
        k++;
      end else begin
        sio.sdrd = 1'($urandom);
      end
      if (sio.done) begin
        finished = 1'b1;
        if (sb_q.size() == 0) begin
          fail_now("done_unexpected");
        end else begin
          e = sb_q.pop_front();
          check("done_cyc", cyc, e.done_cyc);
          check("result",   32'(sio.result), 32'(e.result));
          check("err",      32'(sio.err),    32'(e.err));
        end
        check("done_busy", 32'(sio.busy),    32'd0);
        check("done_req",  32'(sio.bus_req), 32'd0);
        check_idle_bus("done");
      end else if (rel > v.exp_len + 20) begin
        finished = 1'b1;
        fail_now("done_timeout");
        sb_q.delete();
      end
      prev_sser_n = sio.sser_n;
      prev_ba_lo  = sio.ba_lo;
    end
    check("strobe_count", k, (v.drop_read >= 0) ? (5 + v.drop_read) : (4 + NBITS));
    sio.start   = 1'b0;
    sio.bus_gnt = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("post_done",   32'(sio.done),   32'd0);
      check("post_busy",   32'(sio.busy),   32'd0);
      check("post_err",    32'(sio.err),    32'(v.exp_err));
      check("post_result", 32'(sio.result), 32'(v.exp_result));
      check("post_sser_n", 32'(sio.sser_n), 32'd1);
    end
  endtask

  // Reset asserted during the second key strobe; called at a falling edge.
  task automatic reset_mid_key();
    int t0;
    int rel;
    int k;
    bit hit;
    t0  = cyc;
    k   = 0;
    rel = 0;
    hit = 1'b0;
    sio.start   = 1'b1;
    sio.key     = 16'h3C96;
    sio.bus_gnt = 1'b1;
    while (!hit) begin
      @(negedge clk);
      rel = cyc - t0;
      sio.start = 1'b0;
      if (!sio.sser_n) k++;
      if (k == 2) begin
        hit = 1'b1;
        rst = 1'b1;
      end else if (rel > 30) begin
        hit = 1'b1;
        fail_now("rst_strobe_timeout");
      end
    end
    check("rst_strobe_cyc", rel, 3 + PERIOD);
    @(negedge clk);
    check("rst_busy",   32'(sio.busy),    32'd0);
    check("rst_done",   32'(sio.done),    32'd0);
    check("rst_err",    32'(sio.err),     32'd0);
    check("rst_result", 32'(sio.result),  32'd0);
    check("rst_req",    32'(sio.bus_req), 32'd0);
    check_idle_bus("rst");
    rst = 1'b0;
    sb_q.delete();
    repeat (6) begin
      @(negedge clk);
      check("rst_no_done",  32'(sio.done),    32'd0);
      check("rst_no_busy",  32'(sio.busy),    32'd0);
      check("rst_no_req",   32'(sio.bus_req), 32'd0);
      check("rst_no_sser",  32'(sio.sser_n),  32'd1);
    end
  endtask

  initial begin
    // key, data, gnt_delay, drop_read, extra_start, exp_result, exp_err, exp_len
    vecs[0] = '{16'hA5C3, 16'hBEEF, 0, -1, -1, 16'hBEEF, 1'b0, 43}; // nominal
    vecs[1] = '{16'hA5C3, 16'hBEEF, 7, -1, -1, 16'hBEEF, 1'b0, 50}; // late grant
    vecs[2] = '{16'h1234, 16'h0F0F, 0,  4, -1, 16'hBEEF, 1'b1, 21}; // grant loss
    vecs[3] = '{16'h1234, 16'h1357, 0, -1, 25, 16'h1357, 1'b0, 43}; // start while busy
    vecs[4] = '{16'h0F0F, 16'h8001, 0, -1, -1, 16'h8001, 1'b0, 43}; // edge bits
    vecs[5] = '{16'h3C96, 16'h6A5B, 0, -1, -1, 16'h6A5B, 1'b0, 43}; // after reset

    n_cmp       = 0;
    n_bad       = 0;
    rst         = 1'b1;
    sio.start   = 1'b0;
    sio.key     = 16'h0000;
    sio.bus_gnt = 1'b1;
    sio.sdrd    = 1'b0;
    repeat (3) @(negedge clk);
    check("init_busy",   32'(sio.busy),    32'd0);
    check("init_done",   32'(sio.done),    32'd0);
    check("init_err",    32'(sio.err),     32'd0);
    check("init_result", 32'(sio.result),  32'd0);
    check("init_req",    32'(sio.bus_req), 32'd0);
    check_idle_bus("init");
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);
    reset_mid_key();
    run_vec(vecs[5]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cle283_seq.md
# cle283_seq

Bus-cycle sequencer for the CLE283 serial-ID state machine in the $1xxx decode window. On a start request it obtains the shared backplane bus and issues four key strobes to step the CLE283 registers. It then issues NBITS read strobes, shifting the sampled SDRD line into a result word, and releases the bus. It sits between the diagnostic/boot controller (start/result side) and the backplane bus arbiter (req/gnt side).

## Interface
- NBITS, 16: number of read strobes and result width; 1..32.
- READ_NIB, 4'h0: value driven on BA7..BA4 during read strobes.
- GAP, 1: idle cycles (sser_n high) between consecutive strobes; 1..15.

- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; honoured only in IDLE.
- key  in  16  four key nibbles, sampled on the accepted start; key[15:12] is issued first.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at the end of a run, including aborted runs.
- err  out  1  valid with done: 1 means aborted by grant loss. Holds until the next accepted start.
- result  out  NBITS  sampled bits. Updated only on a successful done; otherwise holds.
- bus_req  out  1  bus request to the arbiter.
- bus_gnt  in  1  grant from the arbiter.
- ba13, ba12  out  1 each  window select. Idle value is 1/0 (outside the window); active value is 0/1.
- ba_lo  out  4  BA7..BA4.
- sser_n  out  1  serial strobe, active low.
- br_w  out  1  bus read/write; driven 1 (read) throughout.
- sdrd  in  1  serial read data; valid only while sser_n is low.

## Operation
- States: IDLE → REQ → KEY → READ → REL → IDLE; ABORT is reachable from REQ-grant-held states.
- IDLE: on start=1, latch key, clear the shift register and enter REQ.
- REQ: assert bus_req and wait for bus_gnt=1 with no timeout. The first strobe follows after GAP idle cycles.
- Strobe cycle:
  - Exactly one clk cycle with sser_n=0, ba13=0, ba12=1, br_w=1 and ba_lo valid.
  - ba_lo is already stable during the preceding idle cycle and is held through it.
  - Strobes are separated by exactly GAP idle cycles with sser_n=1.
- KEY: four strobes with ba_lo = key[15:12], key[11:8], key[7:4], key[3:0] in that order. No sampling.
- READ:
  - NBITS strobes with ba_lo=READ_NIB.
  - sdrd is sampled at the rising edge that ends each strobe cycle.
  - Shift left; the first bit sampled ends in result[NBITS-1].
- REL: drop bus_req, return the bus outputs to idle values, load result, pulse done with err=0, then go to IDLE.
- Grant loss: bus_gnt=0 in any cycle after the first grant and before REL sends the block to ABORT.
  - Bus outputs return to idle and bus_req drops on the next edge.
  - A strobe in flight completes its cycle but is not sampled.
  - done and err are pulsed, result is unchanged, then IDLE.
- start while busy is ignored; it is neither queued nor counted.
- Idle bus values, whenever not strobing: sser_n=1, ba13=1, ba12=0, ba_lo=0, br_w=1.
- Counters: strobe count is 0..max(4, NBITS)-1 and the gap count is 0..GAP-1. Neither may wrap. Terminal counts decide transitions.

## Timing
- Reset values:
  - busy=0, done=0, err=0, result=0, bus_req=0.
  - sser_n=1, ba13=1, ba12=0, ba_lo=0, br_w=1.
  - State is IDLE.
- rst mid-run: all outputs take reset values at that edge, with no done pulse. The bus is released at once.
- start at edge T gives bus_req=1 and busy=1 at T+1.
- With bus_gnt already high, the first strobe is at cycle T+2+GAP.
- Strobe spacing is GAP+1 cycles.
- Total length, gnt held from T+1: done pulses at T+2+GAP + (4+NBITS)(GAP+1) + 1 - GAP.
  - This equals T+3+(4+NBITS)(GAP+1).
  - The last strobe ends, then REL takes 1 cycle, and done appears on the cycle after REL.
- busy falls in the same cycle done rises.
- bus_req falls in the cycle done rises.

## Test plan
- Nominal run: NBITS=16, GAP=1, gnt tied high, key=16'hA5C3, sdrd replays 16'hBEEF MSB-first → ba_lo sequence A,5,C,3 then sixteen 0s; result=16'hBEEF; err=0; done at T+43.
- Delayed grant: gnt rises 7 cycles after bus_req → no sser_n low before the grant; every strobe shifts by exactly 7 cycles; result is unchanged versus the nominal run.
- Grant loss: gnt drops during the 5th read strobe → idle bus values and bus_req=0 on the next edge; done=1, err=1; result keeps its prior value.
- Start while busy: a second start mid-READ → no effect; exactly one done; the next start after IDLE runs normally.
- Reset mid-KEY: rst on the 2nd key strobe → all outputs at reset values on the next edge; no done; a following start repeats the full key sequence.
- Strobe hygiene, across all runs:
  - sser_n is never low for more than 1 cycle.
  - ba_lo never changes while sser_n=0.
  - ba13/ba12 = 0/1 whenever sser_n=0.
  - br_w is always 1.
